// File: rtl/mcb_port_pkg.sv
// Shared definitions for the MCB user-port responder: instruction codes,
// command record layout, FIFO depths and the sequencer state type.
package mcb_port_pkg;

    localparam logic [2:0] INSTR_WRITE    = 3'b000;
    localparam logic [2:0] INSTR_READ     = 3'b001;
    localparam logic [2:0] INSTR_WRITE_AP = 3'b010;
    localparam logic [2:0] INSTR_READ_AP  = 3'b011;

    localparam int CMD_FIFO_DEPTH  = 4;
    localparam int DATA_FIFO_DEPTH = 64;
    localparam int DATA_FIFO_CNT_W = $clog2(DATA_FIFO_DEPTH + 1);

    typedef struct packed {
        logic [2:0]  instr;
        logic [5:0]  bl;
        logic [29:0] addr;
    } mcb_cmd_t;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_WRITE,
        ST_READ
    } mcb_state_e;

    function automatic logic is_write_instr(input logic [2:0] instr);
        return (instr == INSTR_WRITE) || (instr == INSTR_WRITE_AP);
    endfunction

    function automatic logic is_read_instr(input logic [2:0] instr);
        return (instr == INSTR_READ) || (instr == INSTR_READ_AP);
    endfunction

endpackage

// File: rtl/mcb_sync_fifo.sv
// Single-clock FIFO with occupancy count; DEPTH must be a power of two.
// FWFT=1 presents the head word combinationally from storage (zero when empty).
module mcb_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter bit FWFT  = 1'b1,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign count   = cnt_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din;
    end

    if (FWFT) begin : g_fwft
        assign dout = empty ? '0 : mem_q[rptr_q];
    end else begin : g_registered
        logic [WIDTH-1:0] dout_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)      dout_q <= '0;
            else if (do_pop) dout_q <= mem_q[rptr_q];
        end
        assign dout = dout_q;
    end

endmodule

// File: rtl/mcb_port_responder.sv
// BRAM-backed memory-side end of an MCB user port: command, write-data and
// read-data FIFOs in front of a byte-maskable synchronous RAM.
module mcb_port_responder
    import mcb_port_pkg::*;
#(
    parameter int DATA_WIDTH   = 128,
    parameter int MASK_SIZE    = DATA_WIDTH / 8,
    parameter int MEM_DEPTHBIT = 10,
    parameter int CALIB_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  calib_done,
    input  logic                  cmd_en,
    input  logic [2:0]            cmd_instr,
    input  logic [5:0]            cmd_bl,
    input  logic [29:0]           cmd_byte_addr,
    output logic                  cmd_empty,
    output logic                  cmd_full,
    input  logic                  wr_en,
    input  logic [MASK_SIZE-1:0]  wr_mask,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_full,
    output logic                  wr_empty,
    output logic [6:0]            wr_count,
    output logic                  wr_underrun,
    output logic                  wr_error,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_full,
    output logic                  rd_empty,
    output logic [6:0]            rd_count,
    output logic                  rd_overflow,
    output logic                  rd_error
);

    localparam int CAL_W     = (CALIB_CYCLES > 1) ? $clog2(CALIB_CYCLES) : 1;
    localparam int WQ_W      = DATA_WIDTH + MASK_SIZE;
    localparam int RAM_WORDS = 2 ** MEM_DEPTHBIT;
    localparam int CMD_CNT_W = $clog2(CMD_FIFO_DEPTH + 1);

    mcb_state_e              state_q, state_d;
    logic [CAL_W-1:0]        cal_cnt_q, cal_cnt_d;
    logic [5:0]              beats_q, beats_d;
    logic [MEM_DEPTHBIT-1:0] addr_q, addr_d;

    logic                    cmd_pop, wr_pop, ram_we, ram_re;
    mcb_cmd_t                cmd_in, cmd_head;
    logic [CMD_CNT_W-1:0]    cmd_count_unused;
    logic [WQ_W-1:0]         wq_head;
    logic [MASK_SIZE-1:0]    wq_mask;
    logic [DATA_WIDTH-1:0]   wq_data;

    logic [DATA_WIDTH-1:0]   ram [RAM_WORDS];
    logic [DATA_WIDTH-1:0]   ram_rdata_q;
    logic                    rd_vld_q;
    logic                    underrun_now, overflow_now;
    logic                    wr_underrun_q, wr_error_q, rd_overflow_q, rd_error_q;
    logic                    unused_addr_bits;

    assign calib_done = (state_q != ST_INIT);
    assign cmd_in     = '{instr: cmd_instr, bl: cmd_bl, addr: cmd_byte_addr};
    assign wq_mask    = wq_head[WQ_W-1:DATA_WIDTH];
    assign wq_data    = wq_head[DATA_WIDTH-1:0];
    assign unused_addr_bits = ^{cmd_head.addr[29:MEM_DEPTHBIT+4], cmd_head.addr[3:0], cmd_count_unused};

    mcb_sync_fifo #(
        .WIDTH ($bits(mcb_cmd_t)),
        .DEPTH (CMD_FIFO_DEPTH),
        .FWFT  (1'b1),
        .CNT_W (CMD_CNT_W)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_en && calib_done),
        .din   (cmd_in),
        .pop   (cmd_pop),
        .dout  (cmd_head),
        .empty (cmd_empty),
        .full  (cmd_full),
        .count (cmd_count_unused)
    );

    mcb_sync_fifo #(
        .WIDTH (WQ_W),
        .DEPTH (DATA_FIFO_DEPTH),
        .FWFT  (1'b1),
        .CNT_W (DATA_FIFO_CNT_W)
    ) u_wr_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wr_en && calib_done),
        .din   ({wr_mask, wr_data}),
        .pop   (wr_pop),
        .dout  (wq_head),
        .empty (wr_empty),
        .full  (wr_full),
        .count (wr_count)
    );

    mcb_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DATA_FIFO_DEPTH),
        .FWFT  (1'b1),
        .CNT_W (DATA_FIFO_CNT_W)
    ) u_rd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rd_vld_q),
        .din   (ram_rdata_q),
        .pop   (rd_en),
        .dout  (rd_data),
        .empty (rd_empty),
        .full  (rd_full),
        .count (rd_count)
    );

    always_comb begin
        state_d   = state_q;
        cal_cnt_d = cal_cnt_q;
        beats_d   = beats_q;
        addr_d    = addr_q;
        cmd_pop   = 1'b0;
        wr_pop    = 1'b0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                if (cal_cnt_q == CAL_W'(CALIB_CYCLES - 1)) state_d = ST_IDLE;
                else                                       cal_cnt_d = cal_cnt_q + 1'b1;
            end
            ST_IDLE: begin
                if (!cmd_empty) begin
                    cmd_pop = 1'b1;
                    beats_d = cmd_head.bl;
                    addr_d  = cmd_head.addr[MEM_DEPTHBIT+3:4];
                    if (is_write_instr(cmd_head.instr))     state_d = ST_WRITE;
                    else if (is_read_instr(cmd_head.instr)) state_d = ST_READ;
                end
            end
            // An empty write FIFO still consumes the beat; only the RAM write is skipped.
            ST_WRITE: begin
                wr_pop  = 1'b1;
                ram_we  = !wr_empty;
                addr_d  = addr_q + 1'b1;
                beats_d = beats_q - 1'b1;
                if (beats_q == '0) state_d = ST_IDLE;
            end
            ST_READ: begin
                ram_re  = 1'b1;
                addr_d  = addr_q + 1'b1;
                beats_d = beats_q - 1'b1;
                if (beats_q == '0) state_d = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            cal_cnt_q <= '0;
            beats_q   <= '0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            cal_cnt_q <= cal_cnt_d;
            beats_q   <= beats_d;
            addr_q    <= addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int unsigned b = 0; b < MASK_SIZE; b++) begin
                if (!wq_mask[b]) ram[addr_q][b*8 +: 8] <= wq_data[b*8 +: 8];
            end
        end
        if (ram_re) ram_rdata_q <= ram[addr_q];
    end

    assign underrun_now = (state_q == ST_WRITE) && wr_empty;
    assign overflow_now = rd_vld_q && rd_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q      <= 1'b0;
            wr_underrun_q <= 1'b0;
            wr_error_q    <= 1'b0;
            rd_overflow_q <= 1'b0;
            rd_error_q    <= 1'b0;
        end else begin
            rd_vld_q      <= ram_re;
            wr_underrun_q <= underrun_now;
            wr_error_q    <= wr_error_q | underrun_now;
            rd_overflow_q <= overflow_now;
            rd_error_q    <= rd_error_q | overflow_now;
        end
    end

    assign wr_underrun = wr_underrun_q;
    assign wr_error    = wr_error_q;
    assign rd_overflow = rd_overflow_q;
    assign rd_error    = rd_error_q;

endmodule

// File: tb/tb_mcb_port_responder.sv
// Directed bench for mcb_port_responder with a command-level memory model
// that predicts read beats, underruns and overflows.
module tb_mcb_port_responder;

    localparam int DW  = 128;
    localparam int MS  = 16;
    localparam int DB  = 10;
    localparam int CAL = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          calib_done;
    logic          cmd_en = 1'b0;
    logic [2:0]    cmd_instr = '0;
    logic [5:0]    cmd_bl = '0;
    logic [29:0]   cmd_byte_addr = '0;
    logic          cmd_empty, cmd_full;
    logic          wr_en = 1'b0;
    logic [MS-1:0] wr_mask = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_full, wr_empty;
    logic [6:0]    wr_count;
    logic          wr_underrun, wr_error;
    logic          rd_en = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_full, rd_empty;
    logic [6:0]    rd_count;
    logic          rd_overflow, rd_error;

    mcb_port_responder #(
        .DATA_WIDTH   (DW),
        .MASK_SIZE    (MS),
        .MEM_DEPTHBIT (DB),
        .CALIB_CYCLES (CAL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .calib_done    (calib_done),
        .cmd_en        (cmd_en),
        .cmd_instr     (cmd_instr),
        .cmd_bl        (cmd_bl),
        .cmd_byte_addr (cmd_byte_addr),
        .cmd_empty     (cmd_empty),
        .cmd_full      (cmd_full),
        .wr_en         (wr_en),
        .wr_mask       (wr_mask),
        .wr_data       (wr_data),
        .wr_full       (wr_full),
        .wr_empty      (wr_empty),
        .wr_count      (wr_count),
        .wr_underrun   (wr_underrun),
        .wr_error      (wr_error),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_full       (rd_full),
        .rd_empty      (rd_empty),
        .rd_count      (rd_count),
        .rd_overflow   (rd_overflow),
        .rd_error      (rd_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [MS-1:0] mask;
        logic [DW-1:0] data;
    } wbeat_t;

    int            checks = 0;
    int            errors = 0;
    wbeat_t        wq[$];
    logic [DW-1:0] exp_rd[$];
    logic [DW-1:0] mram [1 << DB];
    int            exp_underrun = 0;
    int            exp_overflow = 0;
    int            seen_underrun = 0;
    int            seen_overflow = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Commands are applied to the model whole, in issue order.
    task automatic model_cmd(input logic [2:0] instr, input logic [5:0] bl, input logic [29:0] addr);
        logic [DB-1:0] idx;
        wbeat_t        wb;
        for (int k = 0; k <= int'(bl); k++) begin
            idx = addr[DB+3:4] + DB'(k);
            if (instr == 3'd0 || instr == 3'd2) begin
                if (wq.size() == 0) exp_underrun++;
                else begin
                    wb = wq.pop_front();
                    for (int b = 0; b < MS; b++)
                        if (!wb.mask[b]) mram[idx][b*8 +: 8] = wb.data[b*8 +: 8];
                end
            end else if (instr == 3'd1 || instr == 3'd3) begin
                if (exp_rd.size() >= 64) exp_overflow++;
                else exp_rd.push_back(mram[idx]);
            end
        end
    endtask

    task automatic push_wr(input logic [DW-1:0] d, input logic [MS-1:0] m);
        wr_en = 1'b1;
        wr_data = d;
        wr_mask = m;
        tick(1);
        wr_en = 1'b0;
        wq.push_back('{mask: m, data: d});
    endtask

    task automatic send_cmd(input logic [2:0] instr, input logic [5:0] bl, input logic [29:0] addr);
        cmd_en = 1'b1;
        cmd_instr = instr;
        cmd_bl = bl;
        cmd_byte_addr = addr;
        tick(1);
        cmd_en = 1'b0;
        model_cmd(instr, bl, addr);
    endtask

    task automatic drain();
        int guard = 0;
        tick(4);
        while (!rd_empty && guard < 100) begin
            rd_en = 1'b1;
            tick(1);
            guard++;
        end
        rd_en = 1'b0;
        chk("rd_drained", exp_rd.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_underrun) seen_underrun++;
            if (rd_overflow) seen_overflow++;
            if (rd_en && !rd_empty) begin
                if (exp_rd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: got %0h with no beat expected", rd_data);
                end else begin
                    chkw("rd_beat", rd_data, exp_rd.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, got %0d checks expected completion", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;

        tick(3);
        chk("rst_calib_done", int'(calib_done), 0);
        chk("rst_cmd_empty", int'(cmd_empty), 1);
        chk("rst_cmd_full", int'(cmd_full), 0);
        chk("rst_wr_empty", int'(wr_empty), 1);
        chk("rst_wr_full", int'(wr_full), 0);
        chk("rst_wr_count", int'(wr_count), 0);
        chk("rst_rd_empty", int'(rd_empty), 1);
        chk("rst_rd_full", int'(rd_full), 0);
        chk("rst_rd_count", int'(rd_count), 0);
        chk("rst_errors", int'({wr_error, rd_error, wr_underrun, rd_overflow}), 0);
        chkw("rst_rd_data", rd_data, '0);

        // Calibration window: pushes are dropped, done rises on the 64th edge.
        rst_n = 1'b1;
        tick(10);
        cmd_en = 1'b1;
        cmd_instr = 3'd0;
        wr_en = 1'b1;
        wr_data = '1;
        tick(3);
        cmd_en = 1'b0;
        wr_en = 1'b0;
        chk("init_cmd_empty", int'(cmd_empty), 1);
        chk("init_wr_empty", int'(wr_empty), 1);
        chk("init_rd_empty", int'(rd_empty), 1);
        tick(50);
        chk("calib_edge63", int'(calib_done), 0);
        tick(1);
        chk("calib_edge64", int'(calib_done), 1);

        // Write 4 beats then read them back; first beat at N+4.
        for (int k = 1; k <= 4; k++) push_wr(DW'(k), '0);
        send_cmd(3'd0, 6'd3, 30'h100);
        tick(10);
        send_cmd(3'd1, 6'd3, 30'h100);
        tick(2);
        chk("rd_empty_at_n3", int'(rd_empty), 1);
        tick(1);
        chk("rd_empty_at_n4", int'(rd_empty), 0);
        chkw("rd_first_beat", rd_data, 128'h1);
        drain();

        // Byte mask: only byte 0 replaced.
        push_wr('1, '0);
        send_cmd(3'd0, 6'd0, 30'h400);
        tick(6);
        push_wr(DW'(8'h5A), 16'hFFFE);
        send_cmd(3'd0, 6'd0, 30'h400);
        tick(6);
        send_cmd(3'd1, 6'd0, 30'h400);
        tick(3);
        chkw("mask_merge", rd_data, {{15{8'hFF}}, 8'h5A});
        drain();

        // Underrun: bl=7 with 5 beats queued.
        chk("wr_error_before", int'(wr_error), 0);
        for (int k = 0; k < 8; k++) push_wr(DW'(32'hA0 + k), '0);
        send_cmd(3'd0, 6'd7, 30'h800);
        tick(12);
        base = seen_underrun;
        for (int k = 0; k < 5; k++) push_wr(DW'(32'hB0 + k), '0);
        send_cmd(3'd0, 6'd7, 30'h800);
        tick(12);
        chk("underrun_pulses", seen_underrun - base, 3);
        chk("underrun_model", seen_underrun, exp_underrun);
        chk("wr_error_sticky", int'(wr_error), 1);
        send_cmd(3'd1, 6'd7, 30'h800);
        tick(3);
        chkw("underrun_beat0", rd_data, 128'hB0);
        drain();

        // Overflow: two 64-beat reads with no pops.
        chk("rd_error_before", int'(rd_error), 0);
        for (int k = 0; k < 64; k++) push_wr(DW'(32'h1000 + k), '0);
        chk("wr_full_64", int'(wr_full), 1);
        chk("wr_count_64", int'(wr_count), 64);
        send_cmd(3'd0, 6'd63, 30'h2000);
        tick(70);
        base = seen_overflow;
        send_cmd(3'd1, 6'd63, 30'h2000);
        send_cmd(3'd1, 6'd63, 30'h2000);
        tick(140);
        chk("rd_full_64", int'(rd_full), 1);
        chk("rd_count_64", int'(rd_count), 64);
        chk("overflow_pulses", seen_overflow - base, 64);
        chk("overflow_model", seen_overflow, exp_overflow);
        chk("rd_error_sticky", int'(rd_error), 1);
        drain();

        // Wrap at the last word: 1023, 0, 1, 2.
        for (int k = 0; k < 4; k++) push_wr(DW'(32'hC0 + k), '0);
        send_cmd(3'd0, 6'd3, 30'h3FF0);
        tick(8);
        send_cmd(3'd1, 6'd0, 30'h0);
        tick(3);
        chkw("wrap_word0", rd_data, 128'hC1);
        drain();
        send_cmd(3'd1, 6'd3, 30'h3FF0);
        drain();

        // Undefined instruction: popped and discarded, nothing moves.
        push_wr(DW'(32'hD0), '0);
        tick(2);
        send_cmd(3'd4, 6'd3, 30'h100);
        tick(10);
        chk("discard_wr_count", int'(wr_count), 1);
        chk("discard_rd_count", int'(rd_count), 0);
        chk("discard_cmd_empty", int'(cmd_empty), 1);
        send_cmd(3'd0, 6'd0, 30'h500);
        tick(6);
        chk("discard_wr_used", int'(wr_empty), 1);
        send_cmd(3'd1, 6'd0, 30'h500);
        drain();

        // Reset in the middle of a read burst (not modelled: data is discarded).
        wr_en = 1'b1;
        wr_data = '0;
        cmd_en = 1'b1;
        cmd_instr = 3'd1;
        cmd_bl = 6'd63;
        cmd_byte_addr = 30'h2000;
        tick(1);
        cmd_en = 1'b0;
        wr_en = 1'b0;
        tick(10);
        rst_n = 1'b0;
        #2;
        chk("midrst_calib_done", int'(calib_done), 0);
        chk("midrst_rd_empty", int'(rd_empty), 1);
        chk("midrst_rd_count", int'(rd_count), 0);
        chk("midrst_wr_empty", int'(wr_empty), 1);
        chk("midrst_errors", int'({wr_error, rd_error}), 0);
        chkw("midrst_rd_data", rd_data, '0);
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
